rst_seq: RTL

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/acadia_rst_pkg.sv | 24 ++
 rtl/rst_seq_regs.sv | 99 +++++++++
 rtl/rst_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/acadia_rst_pkg.sv
// -----------------------------------------------------------------------------
// acadia_rst_pkg
// Shared definitions for the reset sequencer: register map, software reset
// key, sequencer state encoding and CAUSE bit positions.
// -----------------------------------------------------------------------------
package acadia_rst_pkg;

  localparam logic [31:0] ADDR_CTRL    = 32'h0000_F100;
  localparam logic [31:0] ADDR_STRETCH = 32'h0000_F104;
  localparam logic [31:0] ADDR_CAUSE   = 32'h0000_F108;

  localparam logic [7:0]  CTRL_KEY     = 8'hA5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } rst_state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;

endpackage

// File: rtl/rst_seq_regs.sv
// -----------------------------------------------------------------------------
// rst_seq_regs
// Register decode and storage for the reset sequencer.
//   CTRL    (write-only, reads 0): keyed software reset request
//   STRETCH (16 bit): reset pulse length, 0 is treated as 1
//   CAUSE   (3 bit, sticky, write-1-to-clear): POR / SW / WDT
// Ports:
//   clk, rst          clock and synchronous active-high power-on reset
//   dmem_addr/rmask/wmask/wdata  data memory bus (full-word writes only)
//   wdt_expire        watchdog expiry pulse, recorded in CAUSE
//   sw_req            combinational: accepted keyed CTRL write this cycle
//   stretch_eff       pulse length to load into the sequencer counter
//   rdata_p1          registered read data, one cycle after the read
// -----------------------------------------------------------------------------
module rst_seq_regs
  import acadia_rst_pkg::*;
#(
  parameter int STRETCH_DEFAULT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  input  logic        wdt_expire,
  output logic        sw_req,
  output logic [15:0] stretch_eff,
  output logic [31:0] rdata_p1
);

  logic [15:0] stretch_q;
  logic [2:0]  cause_q;
  logic [2:0]  cause_set;
  logic [2:0]  cause_clr;
  logic        wr_full;
  logic        wr_ctrl;
  logic        wr_stretch;
  logic        wr_cause;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // A zero length would never leave ASSERT cleanly, so it behaves as one.
  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

  assign wr_full    = (dmem_wmask == 4'hF);
  assign wr_ctrl    = wr_full && (dmem_addr == ADDR_CTRL);
  assign wr_stretch = wr_full && (dmem_addr == ADDR_STRETCH);
  assign wr_cause   = wr_full && (dmem_addr == ADDR_CAUSE);

  assign sw_req = wr_ctrl && (dmem_wdata[31:24] == CTRL_KEY) && dmem_wdata[0];

  assign unused_wdata = ^dmem_wdata[23:16];

  assign stretch_eff = clamp_len(stretch_q);

  always_comb begin
    cause_set            = 3'b000;
    cause_set[CAUSE_SW]  = sw_req;
    cause_set[CAUSE_WDT] = wdt_expire;
    cause_clr            = wr_cause ? dmem_wdata[2:0] : 3'b000;
  end

  always_comb begin
    rd_mux = 32'h0;
    case (dmem_addr)
      ADDR_STRETCH: rd_mux = {16'h0, stretch_q};
      ADDR_CAUSE:   rd_mux = {29'h0, cause_q};
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stretch_q <= 16'(STRETCH_DEFAULT);
      cause_q   <= 3'b001;
    end else begin
      if (wr_stretch) begin
        stretch_q <= dmem_wdata[15:0];
      end
      // Set is applied after the clear so a new event survives a same-cycle W1C.
      cause_q <= (cause_q & ~cause_clr) | cause_set;
    end
  end

  // ---- read stage p1: data appears one cycle after the read, else 0 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1 <= 32'h0;
    end else if (dmem_rmask != 4'h0) begin
      rdata_p1 <= rd_mux;
    end else begin
      rdata_p1 <= 32'h0;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq
// Reset sequencer. Stretches power-on, software and watchdog reset requests
// into a rst_out pulse of STRETCH cycles followed by HOLDOFF_CYCLES of
// enforced low time. Requests during a pulse are absorbed; requests during
// holdoff are held pending and start the next pulse as holdoff ends.
// This block is reset only by sys_rst, never by its own rst_out.
// Ports:
//   sys_clk       system clock
//   sys_rst       synchronous active-high power-on reset
//   wdt_expire    watchdog expiry pulse
//   dmem_addr/rmask/wmask/wdata  register bus
//   rstseq_rdata  register read data (one cycle latency)
//   rst_out       active-high system reset to core_ctrl
// -----------------------------------------------------------------------------
module rst_seq
  import acadia_rst_pkg::*;
#(
  parameter int STRETCH_DEFAULT = 16,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        wdt_expire,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] rstseq_rdata,
  output logic        rst_out
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);
  localparam logic [15:0] POR_LOAD  = 16'(STRETCH_DEFAULT);

  rst_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        sw_req;
  logic        req;
  logic [15:0] stretch_eff;

  rst_seq_regs #(
    .STRETCH_DEFAULT (STRETCH_DEFAULT)
  ) u_regs (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .dmem_addr   (dmem_addr),
    .dmem_rmask  (dmem_rmask),
    .dmem_wmask  (dmem_wmask),
    .dmem_wdata  (dmem_wdata),
    .wdt_expire  (wdt_expire),
    .sw_req      (sw_req),
    .stretch_eff (stretch_eff),
    .rdata_p1    (rstseq_rdata)
  );

  assign req = sw_req | wdt_expire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      ST_RUN: begin
        if (req || pend_q) begin
          state_d = ST_ASSERT;
          cnt_d   = stretch_eff;
          pend_d  = 1'b0;
        end
      end
      ST_ASSERT: begin
        // The counter holds the cycles left including this one.
        if (cnt_q <= 16'd1) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_HOLDOFF: begin
        if (req) begin
          pend_d = 1'b1;
        end
        if (cnt_q <= 16'd1) begin
          // A pending (or last-cycle) request skips RUN and starts the next pulse.
          if (pend_q || req) begin
            state_d = ST_ASSERT;
            cnt_d   = stretch_eff;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= POR_LOAD;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign rst_out = (state_q == ST_ASSERT);

endmodule
